// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the cmd_proc command arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Response codes seen on resp_out
  localparam logic [7:0] RESP_DONE    = 8'hA5;
  localparam logic [7:0] RESP_BUSY    = 8'h5A;
  localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

  // Requester indices
  localparam int REQ_UART = 0;
  localparam int REQ_TOUR = 1;
  localparam int REQ_TEST = 2;

endpackage

// File: rtl/cmd_arb_rr_pick.sv
// Round-robin priority picker: first set bit of req searching upward from start, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; any = 0 when no request is set (idx then reads 0).
// Ports: req (request vector), start (search start index), any (a request exists), idx (winner).
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int            s;
  int            c;
  logic [IW-1:0] cand;

  // Scan from the farthest candidate down to the nearest so the nearest
  // set bit overwrites the others. Candidates are reduced modulo N before
  // use, so an index at or above N can never be produced.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    c    = 0;
    cand = '0;
    s    = (int'(start) < N) ? int'(start) : 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = s + k;
      if (c >= N) c = c - N;
      cand = IW'(c);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/cmd_arb.sv
// Arbiter sharing the cmd_proc command/response channel among NUM_REQ sources (0 UART, 1 tour, 2 test).
// Latency: req_rdy in cycle n -> cmd/cmd_rdy/gnt in n+1; send_resp -> resp_vld/resp_out next cycle.
// Backpressure: grant is held until cmd_proc responds; at least one idle cycle between commands.
// Ports: req_cmd/req_rdy/req_clr toward sources; cmd/cmd_rdy/clr_cmd_rdy/send_resp/resp_in toward
// cmd_proc; resp_out + one-hot resp_vld back to the owner; gnt one-hot grant; busy when not IDLE.
// Optional: define CMD_ARB_TIMEOUT_EN for a watchdog that answers RESP_TIMEOUT after TIMEOUT_CYC clocks.
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter int          CMD_W       = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]       req_rdy,
  output logic [NUM_REQ-1:0]       req_clr,
  output logic [CMD_W-1:0]         cmd,
  output logic                     cmd_rdy,
  input  logic                     clr_cmd_rdy,
  input  logic                     send_resp,
  input  logic [7:0]               resp_in,
  output logic [7:0]               resp_out,
  output logic [NUM_REQ-1:0]       resp_vld,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state, state_nxt;
  logic [IW-1:0]       gnt_idx, rr_ptr, pick_idx;
  logic                pick_any;
  logic [CMD_W-1:0]    pick_cmd;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                cap_resp;
  logic [7:0]          cap_val;
  logic                timeout;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_rdy),
    .start (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) pick_cmd = req_cmd[i*CMD_W +: CMD_W];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) gnt_oh[i] = (gnt_idx == IW'(i));
  end

`ifdef CMD_ARB_TIMEOUT_EN
  logic [23:0] wdog;

  // Zero whenever idle/responding, so it starts from 0 on every GRANT entry
  // and keeps counting across GRANT -> EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wdog <= '0;
    else if (state == GRANT || state == EXEC) wdog <= wdog + 24'd1;
    else                                    wdog <= '0;
  end

  assign timeout = (state == GRANT || state == EXEC) && (wdog == TIMEOUT_CYC - 24'd1);
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_clr   = '0;
    cap_resp  = 1'b0;
    cap_val   = resp_in;
    busy      = (state != IDLE);
    gnt       = (state != IDLE) ? gnt_oh : '0;
    resp_vld  = (state == RESP) ? gnt_oh : '0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = GRANT;
      end
      GRANT: begin
        // A timeout also clears the source so it stops re-requesting.
        req_clr = gnt_oh & {NUM_REQ{clr_cmd_rdy | timeout}};
        if (clr_cmd_rdy && send_resp) begin
          cap_resp  = 1'b1;
          state_nxt = RESP;
        end else if (timeout) begin
          cap_resp  = 1'b1;
          cap_val   = RESP_TIMEOUT;
          state_nxt = RESP;
        end else if (clr_cmd_rdy) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // send_resp has priority over a same-cycle timeout.
        if (send_resp) begin
          cap_resp  = 1'b1;
          state_nxt = RESP;
        end else if (timeout) begin
          cap_resp  = 1'b1;
          cap_val   = RESP_TIMEOUT;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      resp_out <= '0;
    end else begin
      // Command is frozen at grant; later req_cmd/req_rdy changes are ignored.
      if (state == IDLE && pick_any) begin
        gnt_idx <= pick_idx;
        cmd     <= pick_cmd;
      end
      cmd_rdy <= (state_nxt == GRANT);
      if (cap_resp) resp_out <= cap_val;
      if (state == RESP) rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
module tb_cmd_arb;
  import cmd_arb_pkg::*;

  localparam int NR = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [47:0]   req_cmd;
  logic [2:0]    req_rdy;
  logic [2:0]    req_clr;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          send_resp;
  logic [7:0]    resp_in;
  logic [7:0]    resp_out;
  logic [2:0]    resp_vld;
  logic [2:0]    gnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #10 clk = ~clk;

  cmd_arb #(.NUM_REQ(NR), .CMD_W(16), .TIMEOUT_CYC(24'(TO))) dut (
    .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_rdy(req_rdy), .req_clr(req_clr),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp_in(resp_in), .resp_out(resp_out), .resp_vld(resp_vld), .gnt(gnt), .busy(busy)
  );

  // Standalone picker with a non-power-of-two size
  logic [4:0] pk_req;
  logic [2:0] pk_start;
  logic       pk_any;
  logic [2:0] pk_idx;
  rr_pick #(.N(5)) u_pk5 (.req(pk_req), .start(pk_start), .any(pk_any), .idx(pk_idx));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 nobody owns the channel, 1 command offered, 2 command accepted,
  // 3 response being returned to the owner.
  int          m_owner = -1;
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_age   = 0;
  logic [15:0] m_cmd   = '0;
  logic [7:0]  m_resp  = '0;
  int          mc;
  bit          m_to;

  function automatic bit m_timeout_now();
`ifdef CMD_ARB_TIMEOUT_EN
    return (m_phase == 1 || m_phase == 2) && (m_age == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] m_oh();
    return (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_phase = 0; m_ptr = 0; m_age = 0; m_cmd = '0; m_resp = '0;
    end else begin
      m_to = m_timeout_now();
      if (m_phase == 1 || m_phase == 2) m_age = m_age + 1;
      case (m_phase)
        0: for (int k = 0; k < NR; k++) begin
             mc = (m_ptr + k) % NR;
             if (m_owner < 0 && req_rdy[mc]) begin
               m_owner = mc; m_cmd = req_cmd[mc*16 +: 16]; m_phase = 1; m_age = 0;
             end
           end
        1: if (clr_cmd_rdy && send_resp) begin m_resp = resp_in; m_phase = 3; end
           else if (m_to) begin m_resp = RESP_TIMEOUT; m_phase = 3; end
           else if (clr_cmd_rdy) m_phase = 2;
        2: if (send_resp) begin m_resp = resp_in; m_phase = 3; end
           else if (m_to) begin m_resp = RESP_TIMEOUT; m_phase = 3; end
        default: begin m_ptr = (m_owner + 1) % NR; m_owner = -1; m_phase = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt", 32'(gnt), 32'(m_oh()));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("cmd_rdy", 32'(cmd_rdy), 32'(m_phase == 1));
      chk("cmd", 32'(cmd), 32'(m_cmd));
      chk("resp_vld", 32'(resp_vld), 32'((m_phase == 3) ? m_oh() : 3'b000));
      chk("resp_out", 32'(resp_out), 32'(m_resp));
      chk("req_clr", 32'(req_clr),
          32'((m_phase == 1 && (clr_cmd_rdy || m_timeout_now())) ? m_oh() : 3'b000));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic serve(input logic [7:0] r, output int who);
    who = -1;
    for (int k = 0; k < 20 && cmd_rdy !== 1'b1; k++) step();
    chk("serve_cmd_rdy_seen", 32'(cmd_rdy), 32'd1);
    for (int i = 0; i < NR; i++) if (gnt[i]) who = i;
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    step();
    send_resp = 1'b1; resp_in = r;
    step();
    send_resp = 1'b0;
    chk("serve_resp_vld_owner", 32'(resp_vld), (who >= 0) ? 32'(1 << who) : 32'hFFFF);
    step();
  endtask

  int order[4];
  logic [4:0] pats[5];
  bit exp_any;
  int exp_idx;
  int clr_seen;
  logic [2:0] clr_val;

  initial begin
    rst = 1'b1; req_cmd = '0; req_rdy = '0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_in = '0;
    pk_req = '0; pk_start = '0;
    #2 cmp_en = 1'b1;

    // Picker standalone: N = 5, every in-range start
    pats[0] = 5'b00000; pats[1] = 5'b10000; pats[2] = 5'b00101; pats[3] = 5'b11111; pats[4] = 5'b01010;
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 5; s++) begin
        pk_req = pats[p]; pk_start = 3'(s);
        #1;
        exp_any = 1'b0; exp_idx = 0;
        for (int k = 0; k < 5; k++) begin
          if (!exp_any && pats[p][(s + k) % 5]) begin exp_any = 1'b1; exp_idx = (s + k) % 5; end
        end
        chk("pick_any", 32'(pk_any), 32'(exp_any));
        if (exp_any) chk("pick_idx", 32'(pk_idx), 32'(exp_idx));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(cmd), 0);
    rst = 1'b0;
    step();

    // Single request from UART
    req_cmd[15:0] = 16'h2002; req_rdy = 3'b001;
    step();
    chk("s1_cmd", 32'(cmd), 32'h2002);
    chk("s1_cmd_rdy", 32'(cmd_rdy), 1);
    chk("s1_gnt", 32'(gnt), 32'b001);
    clr_cmd_rdy = 1'b1; #1;
    chk("s1_req_clr", 32'(req_clr), 32'b001);
    step();
    clr_cmd_rdy = 1'b0; req_rdy = 3'b000;
    clr_cmd_rdy = 1'b1; #1;                      // stray clear in EXEC
    chk("s1_stray_clr_exec", 32'(req_clr), 0);
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1; resp_in = 8'hA5;
    step();
    send_resp = 1'b0;
    chk("s1_resp_vld", 32'(resp_vld), 32'b001);
    chk("s1_resp_out", 32'(resp_out), 32'hA5);
    step();
    chk("s1_resp_vld_gone", 32'(resp_vld), 0);
    chk("s1_gnt_idle", 32'(gnt), 0);

    // Stray handshakes while idle
    send_resp = 1'b1; clr_cmd_rdy = 1'b1; resp_in = 8'h11;
    step();
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    chk("idle_stray_busy", 32'(busy), 0);
    chk("idle_stray_resp_out", 32'(resp_out), 32'hA5);

    // Round-robin from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    req_cmd = {16'h1003, 16'h1002, 16'h1001}; req_rdy = 3'b111;
    for (int n = 0; n < 4; n++) serve(RESP_DONE, order[n]);
    req_rdy = 3'b000;
    chk("rr_order0", 32'(order[0]), 0);
    chk("rr_order1", 32'(order[1]), 1);
    chk("rr_order2", 32'(order[2]), 2);
    chk("rr_order3", 32'(order[3]), 0);
    step();

    // Accept and complete in the same GRANT cycle
    req_rdy = 3'b100;
    step();
    chk("s3_gnt", 32'(gnt), 32'b100);
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; resp_in = RESP_BUSY;
    step();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; req_rdy = 3'b000;
    chk("s3_resp_out", 32'(resp_out), 32'h5A);
    chk("s3_resp_vld", 32'(resp_vld), 32'b100);
    step();

    // Command stability after grant
    req_cmd[31:16] = 16'h3BF1; req_rdy = 3'b010;
    step();
    req_cmd[31:16] = 16'h0000;
    #1 chk("s4_cmd_grant", 32'(cmd), 32'h3BF1);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0; req_rdy = 3'b000;
    step();
    chk("s4_cmd_exec", 32'(cmd), 32'h3BF1);
    send_resp = 1'b1; resp_in = RESP_DONE;
    step();
    send_resp = 1'b0;
    chk("s4_cmd_resp", 32'(cmd), 32'h3BF1);
    chk("s4_resp_vld", 32'(resp_vld), 32'b010);
    step();

    // Reset while executing
    req_cmd[15:0] = 16'h2002; req_rdy = 3'b001;
    step();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0; req_rdy = 3'b000;
    chk("s5_busy_exec", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("s5_rst_gnt", 32'(gnt), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_cmd", 32'(cmd), 0);
    chk("s5_rst_cmd_rdy", 32'(cmd_rdy), 0);
    chk("s5_rst_resp", 32'({resp_out, resp_vld}), 0);
    step(); step();
    rst = 1'b0; req_rdy = 3'b010;
    step();
    chk("s5_gnt_after_rst", 32'(gnt), 32'b010);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0; req_rdy = 3'b000; send_resp = 1'b1; resp_in = RESP_DONE;
    step();
    send_resp = 1'b0;
    step();

`ifdef CMD_ARB_TIMEOUT_EN
    // cmd_proc never answers
    req_rdy = 3'b001; clr_seen = -1; clr_val = '0;
    step();
    for (int k = 0; k < 40 && resp_vld === 3'b000; k++) begin
      if (req_clr !== 3'b000) begin clr_seen = k; clr_val = req_clr; req_rdy = 3'b000; end
      if (resp_vld === 3'b000) step();
    end
    chk("to_req_clr", 32'(clr_val), 32'b001);
    chk("to_req_clr_cycle", 32'(clr_seen), 32'(TO - 1));
    chk("to_resp_out", 32'(resp_out), 32'hEE);
    chk("to_resp_vld", 32'(resp_vld), 32'b001);
    step();
    chk("to_idle", 32'(busy), 0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cmd_arb.md
Name: cmd_arb

Overview:
- Shares the single cmd_proc command/response channel among NUM_REQ command sources: UART wrapper, tour command sequencer and a calibration/test source.
- Each requester presents a 16-bit cmd plus a cmd_rdy level. The arbiter grants one requester per command and holds the grant until cmd_proc finishes.
- It routes clr_cmd_rdy back to the winning source and returns the 8-bit response only to that source.
- Sits between the command sources and cmd_proc.

Parameters:
- NUM_REQ, 3, number of requesters; must be at least 2. Index 0 = UART, 1 = tour, 2 = test.
- CMD_W, 16, command width.
- TIMEOUT_CYC, 24'hFFFFFF, watchdog limit in clocks. Used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- req_cmd  in  NUM_REQ*CMD_W  packed requester commands; requester i occupies bits [i*CMD_W +: CMD_W].
- req_rdy  in  NUM_REQ  per-requester cmd_rdy level.
- req_clr  out  NUM_REQ  per-requester clear of its cmd_rdy.
- cmd  out  CMD_W  granted command to cmd_proc, registered.
- cmd_rdy  out  1  to cmd_proc, registered.
- clr_cmd_rdy  in  1  from cmd_proc; command accepted.
- send_resp  in  1  from cmd_proc; command complete.
- resp_in  in  8  response byte from cmd_proc.
- resp_out  out  8  registered response byte.
- resp_vld  out  NUM_REQ  one-cycle pulse marking which requester owns resp_out.
- gnt  out  NUM_REQ  one-hot current grant; all zero when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE, rr_ptr = 0.
  - cmd = 0, cmd_rdy = 0, resp_out = 0, resp_vld = 0, gnt = 0, busy = 0.
- Reset mid-operation aborts immediately to the reset values. No req_clr or resp_vld is produced.
- States, package typedef arb_state_t: IDLE, GRANT, EXEC, RESP.
- IDLE:
  - If any req_rdy bit is high, the round-robin pick starts searching at rr_ptr.
  - The winning index is latched into gnt_idx, and its req_cmd slice is latched into cmd.
  - Next state is GRANT.
  - Latency: req_rdy high in cycle n gives cmd_rdy = 1 and gnt valid in cycle n+1.
- GRANT:
  - cmd_rdy = 1.
  - req_clr[gnt_idx] = clr_cmd_rdy, combinational pass-through.
  - On clr_cmd_rdy, next state is EXEC and cmd_rdy goes to 0 in the next cycle.
  - If clr_cmd_rdy and send_resp occur together, resp_in is captured and next state is RESP.
- EXEC:
  - cmd_rdy = 0 and cmd is held.
  - On send_resp, resp_out <= resp_in and next state is RESP.
- RESP:
  - resp_vld[gnt_idx] = 1 for exactly one cycle.
  - rr_ptr <= (gnt_idx == NUM_REQ-1) ? 0 : gnt_idx+1.
  - Next state is IDLE and gnt clears.
  - A new grant can begin on the cycle after RESP, so back-to-back commands cost at least 1 idle cycle.
- The command is latched at grant. Changes to req_cmd, or the requester dropping req_rdy after the grant, do not alter the command in flight.
- Stray inputs:
  - send_resp or clr_cmd_rdy while in IDLE is ignored.
  - clr_cmd_rdy while in EXEC is ignored, and req_clr stays 0.
- Bits of req_clr for non-granted requesters are always 0.
- Arbitration widths:
  - gnt_idx is $clog2(NUM_REQ) bits.
  - The round-robin search wraps modulo NUM_REQ.
  - The pick must not select an index at or above NUM_REQ when NUM_REQ is not a power of two.

Optional Feature:
- Macro: CMD_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog counter clears on entry to GRANT and counts in GRANT and EXEC.
  - On reaching TIMEOUT_CYC-1 without completion, resp_out <= RESP_TIMEOUT (8'hEE) and next state is RESP; the normal RESP behaviour applies.
  - If timeout fires while in GRANT, req_clr[gnt_idx] pulses in that cycle so the source drops its request.
  - If send_resp and timeout occur in the same cycle, send_resp wins and resp_in is used.
- Undefined: no counter, and the arbiter waits indefinitely for cmd_proc.

Decomposition:
- Package cmd_arb_pkg:
  - arb_state_t.
  - RESP_DONE = 8'hA5, RESP_BUSY = 8'h5A, RESP_TIMEOUT = 8'hEE.
  - REQ_UART = 0, REQ_TOUR = 1, REQ_TEST = 2.
- Sub-module rr_pick: purely combinational round-robin priority picker.
  - Inputs: req vector and start pointer.
  - Outputs: any and idx.
  - Instantiated once, tested standalone.

Test Plan:
- Single request: req_rdy = 3'b001, req_cmd[15:0] = 16'h2002.
  -> cmd = 16'h2002 and cmd_rdy = 1 one cycle later.
  -> clr_cmd_rdy gives req_clr = 3'b001 in the same cycle.
  -> send_resp with resp_in = 8'hA5 gives resp_vld = 3'b001 and resp_out = 8'hA5 for one cycle.
- Round-robin: all three req_rdy held high, cmd_proc completes each command.
  -> Grant order is 0, 1, 2, 0.
  -> Each resp_vld pulse matches the prior gnt.
- Simultaneous clr_cmd_rdy and send_resp in GRANT with resp_in = 8'h5A -> RESP in the next cycle, resp_out = 8'h5A.
- Command stability: req_cmd[31:16] changes from 16'h3BF1 to 16'h0000 after grant -> cmd stays 16'h3BF1 until RESP.
- Reset asserted in EXEC -> all outputs 0 in the same cycle; after release, req 1 pending is granted first because rr_ptr = 0 and no other request is pending.
- With CMD_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 16, and no clr_cmd_rdy -> req_clr pulse, then resp_out = 8'hEE with resp_vld one-hot, then IDLE.
